// File: rtl/coin_collect.sv
// rtl/coin_collect.sv - three-slot coin collector: per-slot EMPTY/ACTIVE/TAKEN FSMs, saturating score
// Optional feature macro: SCORE_BCD_EN (score as four BCD digits instead of binary).
module coin_collect #(
    parameter int HIT_Y_MIN = 400,
    parameter int HIT_Y_MAX = 440,
    parameter int SCORE_MAX = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [5:0]  coins,
    input  logic [26:0] y,
    input  logic [1:0]  player_lane,
    input  logic        game_run,
    output logic [15:0] score,
    output logic        collect,
    output logic [2:0]  hidden
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        TAKEN  = 2'd2
    } slot_state_t;

    localparam logic [8:0] Y_MIN = 9'(HIT_Y_MIN);
    localparam logic [8:0] Y_MAX = 9'(HIT_Y_MAX);

    slot_state_t state [3];
    slot_state_t state_next [3];
    logic [2:0]  hit;
    logic [1:0]  hit_count;
    logic [15:0] score_next;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hit[i] = (state[i] == ACTIVE) && tick && game_run && (player_lane != 2'd0)
                  && (coins[2*i +: 2] == player_lane)
                  && (y[9*i +: 9] >= Y_MIN) && (y[9*i +: 9] <= Y_MAX);
            // An emptied slot always wins over a collection on the same clk.
            if (coins[2*i +: 2] == 2'd0)
                state_next[i] = EMPTY;
            else if (state[i] == EMPTY)
                state_next[i] = ACTIVE;
            else if (hit[i])
                state_next[i] = TAKEN;
            else
                state_next[i] = state[i];
        end
        hit_count = {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};
    end

`ifdef SCORE_BCD_EN
    localparam logic [15:0] MAX_SCORE = {4'((SCORE_MAX / 1000) % 10), 4'((SCORE_MAX / 100) % 10),
                                         4'((SCORE_MAX / 10) % 10), 4'(SCORE_MAX % 10)};

    // Ripple the 1..3 increment through the digits; returns {carry_out, digits}.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [1:0] k);
        logic [4:0]  c;
        logic [4:0]  t;
        logic [15:0] r;
        c = {3'b000, k};
        r = 16'd0;
        for (int d = 0; d < 4; d++) begin
            t = {1'b0, a[4*d +: 4]} + c;
            if (t > 5'd9) begin
                r[4*d +: 4] = 4'(t - 5'd10);
                c = 5'd1;
            end else begin
                r[4*d +: 4] = t[3:0];
                c = 5'd0;
            end
        end
        return {c[0], r};
    endfunction

    logic [16:0] sum;
    always_comb begin
        sum = bcd_add(score, hit_count);
        // Valid BCD compares correctly as plain unsigned.
        score_next = (sum[16] || (sum[15:0] > MAX_SCORE)) ? MAX_SCORE : sum[15:0];
    end
`else
    localparam logic [16:0] MAX_SCORE = 17'(SCORE_MAX);

    logic [16:0] sum;
    always_comb begin
        sum        = {1'b0, score} + {15'd0, hit_count};
        score_next = (sum > MAX_SCORE) ? MAX_SCORE[15:0] : sum[15:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++)
                state[i] <= EMPTY;
            score   <= 16'd0;
            collect <= 1'b0;
            hidden  <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state[i]  <= state_next[i];
                hidden[i] <= (state_next[i] == TAKEN);
            end
            collect <= (hit_count != 2'd0);
            if (hit_count != 2'd0)
                score <= score_next;
        end
    end

endmodule

// File: tb/tb_coin_collect.sv
// tb/tb_coin_collect.sv - scoreboard bench for coin_collect: reference model feeds a queue, monitor compares
module tb_coin_collect;

    localparam int YMIN = 400;
    localparam int YMAX = 440;
    localparam int SMAX = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [5:0]  coins = 6'd0;
    logic [26:0] y = 27'd0;
    logic [1:0]  player_lane = 2'd0;
    logic        game_run = 1'b0;
    logic [15:0] score;
    logic        collect;
    logic [2:0]  hidden;

    coin_collect #(.HIT_Y_MIN(YMIN), .HIT_Y_MAX(YMAX), .SCORE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .tick(tick), .coins(coins), .y(y),
        .player_lane(player_lane), .game_run(game_run),
        .score(score), .collect(collect), .hidden(hidden)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         score;
        bit         collect;
        bit [2:0]   hidden;
        string      tag;
    } expect_t;

    expect_t exp_q[$];
    int compared = 0;
    int mismatched = 0;

    // Reference model: a coin is collectible once it has been present for a full cycle and
    // has not yet been taken since it last appeared.
    int m_score = 0;
    bit m_present [3];
    bit m_taken [3];

    task automatic step(input int c0, input int c1, input int c2,
                        input int y0, input int y1, input int y2,
                        input int lane, input bit run, input bit tk, input bit r,
                        input string tag);
        int cv [3];
        int yv [3];
        int k;
        expect_t e;
        @(negedge clk);
        cv[0] = c0; cv[1] = c1; cv[2] = c2;
        yv[0] = y0; yv[1] = y1; yv[2] = y2;
        coins = {2'(c2), 2'(c1), 2'(c0)};
        y = {9'(y2), 9'(y1), 9'(y0)};
        player_lane = 2'(lane);
        game_run = run;
        tick = tk;
        rst = r;
        k = 0;
        if (r) begin
            m_score = 0;
            for (int i = 0; i < 3; i++) begin m_present[i] = 0; m_taken[i] = 0; end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cv[i] == 0) begin
                    m_present[i] = 0; m_taken[i] = 0;
                end else if (!m_present[i]) begin
                    m_present[i] = 1;
                end else if (!m_taken[i] && tk && run && lane != 0 && cv[i] == lane
                             && yv[i] >= YMIN && yv[i] <= YMAX) begin
                    m_taken[i] = 1;
                    k++;
                end
            end
            m_score = (m_score + k > SMAX) ? SMAX : m_score + k;
        end
        e.score = m_score;
        e.collect = (k > 0);
        e.hidden = {m_taken[2], m_taken[1], m_taken[0]};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compared++;
                if (score !== 16'(e.score)) begin
                    mismatched++;
                    $display("FAIL %s score: got %0d want %0d", e.tag, score, e.score);
                end
                compared++;
                if (collect !== e.collect) begin
                    mismatched++;
                    $display("FAIL %s collect: got %0b want %0b", e.tag, collect, e.collect);
                end
                compared++;
                if (hidden !== e.hidden) begin
                    mismatched++;
                    $display("FAIL %s hidden: got %03b want %03b", e.tag, hidden, e.hidden);
                end
            end
        end
    end

    initial begin : driver
        int waited;
        int c [3];
        int yy [3];
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");
        // Single coin collected once, further ticks do nothing
        step(2, 0, 0, 420, 0, 0, 2, 1, 0, 0, "one_arm");
        step(2, 0, 0, 420, 0, 0, 2, 1, 1, 0, "one_hit");
        step(2, 0, 0, 420, 0, 0, 2, 1, 1, 0, "one_again");
        step(2, 0, 0, 420, 0, 0, 2, 1, 1, 0, "one_again2");
        // Window edges
        step(0, 3, 0, 0, 399, 0, 3, 1, 1, 0, "edge_arm");
        step(0, 3, 0, 0, 399, 0, 3, 1, 1, 0, "edge_399");
        step(0, 3, 0, 0, 441, 0, 3, 1, 1, 0, "edge_441");
        step(0, 3, 0, 0, 440, 0, 3, 1, 1, 0, "edge_440");
        step(0, 3, 0, 0, 400, 0, 3, 1, 0, 0, "edge_hold");
        // Triple collect on one tick
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "tri_clear");
        step(1, 1, 1, 410, 410, 410, 1, 1, 0, 0, "tri_arm");
        step(1, 1, 1, 410, 410, 410, 1, 1, 1, 0, "tri_hit");
        // Empty then recollect
        step(0, 1, 1, 420, 410, 410, 2, 1, 0, 0, "re_empty");
        step(2, 1, 1, 420, 410, 410, 2, 1, 0, 0, "re_arm");
        step(2, 1, 1, 420, 410, 410, 2, 1, 1, 0, "re_hit");
        // Empty beats collect on the same clk
        step(0, 0, 0, 420, 0, 0, 2, 1, 1, 0, "prio_empty");
        step(2, 0, 0, 420, 0, 0, 2, 1, 0, 0, "prio_arm");
        // No lane / not running
        step(2, 0, 0, 420, 0, 0, 0, 1, 1, 0, "lane0");
        step(2, 0, 0, 420, 0, 0, 2, 0, 1, 0, "norun");
        step(0, 0, 0, 420, 0, 0, 2, 0, 0, 0, "norun_empty");
        step(2, 0, 0, 420, 0, 0, 2, 0, 0, 0, "norun_arm");
        // Reset on a collecting tick, then coin still collectible
        step(2, 0, 0, 420, 0, 0, 2, 1, 1, 1, "rst_tick");
        step(2, 0, 0, 420, 0, 0, 2, 1, 0, 0, "post_rst_arm");
        step(2, 0, 0, 420, 0, 0, 2, 1, 1, 0, "post_rst_hit");
        // Randomized traffic
        for (int i = 0; i < 3; i++) begin c[i] = 0; yy[i] = 420; end
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 7) == 0) c[i] = $urandom_range(0, 3);
                yy[i] = $urandom_range(390, 450);
            end
            step(c[0], c[1], c[2], yy[0], yy[1], yy[2], $urandom_range(0, 3),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) == 0, "random");
        end
        // Saturation: reach 9998 by real collections, then overflow
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "sat_rst");
        for (int r = 0; r < 3333; r++) begin
            step(0, 0, 0, 410, 410, 410, 1, 1, 0, 0, "sat_clr");
            if (r < 3332) begin
                step(1, 1, 1, 410, 410, 410, 1, 1, 0, 0, "sat_arm");
                step(1, 1, 1, 410, 410, 410, 1, 1, 1, 0, "sat_hit");
            end else begin
                step(1, 1, 0, 410, 410, 0, 1, 1, 0, 0, "sat_arm2");
                step(1, 1, 0, 410, 410, 0, 1, 1, 1, 0, "sat_9998");
            end
        end
        step(0, 0, 0, 410, 410, 410, 1, 1, 0, 0, "sat_clr2");
        step(1, 1, 0, 410, 410, 0, 1, 1, 0, 0, "sat_arm3");
        step(1, 1, 0, 410, 410, 0, 1, 1, 1, 0, "sat_9999");
        step(0, 0, 0, 410, 0, 0, 1, 1, 0, 0, "sat_clr3");
        step(1, 0, 0, 410, 0, 0, 1, 1, 0, 0, "sat_arm4");
        step(1, 0, 0, 410, 0, 0, 1, 1, 1, 0, "sat_clamp");
        step(1, 0, 0, 410, 0, 0, 1, 1, 0, 0, "sat_idle");
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
